mrf_nwnr_bypass: RTL and testbench

Parametrised multi-write, multi-read register file with registered read ports, same-cycle write-to-read bypass, optional hardwired-zero entry 0, and a self-clearing init sequencer. It is the next generation of the core's generic N-write/N-read RF primitive. It serves as the architectural and rename-table storage in the ncpu64k pipeline. Software-visible contents are guaranteed zero after reset or after a CLR request, without a reset net on the storage array.

---
 rtl/mrf_nwnr_bypass.sv | 116 +++++++++++
 tb/tb_mrf_nwnr_bypass.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mrf_nwnr_bypass.sv
// Multi-write / multi-read register file with registered read ports, optional
// same-cycle write bypass, optional hardwired-zero entry 0 and a self-clearing init sequencer.
module mrf_nwnr_bypass #(
  parameter int DW        = 64,
  parameter int AW        = 5,
  parameter int NUM_READ  = 4,
  parameter int NUM_WRITE = 2,
  parameter int BYPASS    = 1,
  parameter int R0_ZERO   = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CLR,
  output logic                    READY,
  input  logic [NUM_READ-1:0]     RE,
  input  logic [NUM_READ*AW-1:0]  RADDR,
  output logic [NUM_READ*DW-1:0]  RDATA,
  input  logic [NUM_WRITE-1:0]    WE,
  input  logic [NUM_WRITE*AW-1:0] WADDR,
  input  logic [NUM_WRITE*DW-1:0] WDATA
);

  // state  | meaning
  // S_INIT | sweeping zeros into every entry, accesses ignored
  // S_RUN  | array initialised, reads and writes honoured
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam int DEPTH = 1 << AW;

  state_t              state, state_nxt;
  logic [AW-1:0]       clr_cnt, clr_cnt_nxt;
  logic [DW-1:0]       mem [DEPTH];
  logic [NUM_WRITE-1:0] we_eff;
  logic [DW-1:0]       rd_val [NUM_READ];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      S_INIT: begin
        if (CLR) begin
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
          if (clr_cnt == '1) state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (CLR) begin
          state_nxt   = S_INIT;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = S_INIT;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  assign READY = (state == S_RUN);

  // Writes to entry 0 are masked here so both storage and bypass see them dropped.
  always_comb begin
    we_eff = '0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      we_eff[j] = (state == S_RUN) && WE[j] &&
                  !((R0_ZERO == 1) && (WADDR[j*AW +: AW] == '0));
    end
  end

  // Later loop iterations override earlier ones: highest-index port wins a conflict.
  always_ff @(posedge CLK) begin
    if (state == S_INIT) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (we_eff[j]) mem[WADDR[j*AW +: AW]] <= WDATA[j*DW +: DW];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_val[i] = mem[RADDR[i*AW +: AW]];
      if (BYPASS == 1) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (we_eff[j] && (WADDR[j*AW +: AW] == RADDR[i*AW +: AW]))
            rd_val[i] = WDATA[j*DW +: DW];
        end
      end
      if ((R0_ZERO == 1) && (RADDR[i*AW +: AW] == '0)) rd_val[i] = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RDATA <= '0;
    end else if (state == S_RUN) begin
      for (int i = 0; i < NUM_READ; i++) begin
        if (RE[i]) RDATA[i*DW +: DW] <= rd_val[i];
      end
    end
  end

endmodule

// File: tb/tb_mrf_nwnr_bypass.sv
// Scoreboard bench for mrf_nwnr_bypass: one instance with bypass and zero entry 0,
// one with neither, both driven by shared stimulus and checked against an array model.
module tb_mrf_nwnr_bypass;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clr;
  logic [NR-1:0]  re;
  logic [NR*AW-1:0] raddr;
  logic [NW-1:0]  we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic           ready_a, ready_b;
  logic [NR*DW-1:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  mrf_nwnr_bypass #(.DW(DW), .AW(AW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1), .R0_ZERO(1)) dut_a (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .READY(ready_a), .RE(re), .RADDR(raddr),
    .RDATA(rdata_a), .WE(we), .WADDR(waddr), .WDATA(wdata));

  mrf_nwnr_bypass #(.DW(DW), .AW(AW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0), .R0_ZERO(0)) dut_b (
    .CLK(clk), .RST_N(rst_n), .CLR(clr), .READY(ready_b), .RE(re), .RADDR(raddr),
    .RDATA(rdata_b), .WE(we), .WADDR(waddr), .WDATA(wdata));

  typedef struct {
    int               tag;
    logic             rdy;
    logic [NR*DW-1:0] ea;
    logic [NR*DW-1:0] eb;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  // reference model: contents as software sees them, plus remaining init edges
  logic [DW-1:0]    ma [DEPTH];
  logic [DW-1:0]    mb [DEPTH];
  logic             run_m;
  int               init_left;
  logic [NR*DW-1:0] ea, eb;

  task automatic check(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    run_m = 1'b0;
    init_left = DEPTH;
    ea = '0;
    eb = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
  endtask

  task automatic model_edge();
    exp_t e;
    logic [AW-1:0] a, w;
    logic [DW-1:0] v;
    if (run_m) begin
      for (int i = 0; i < NR; i++) begin
        if (re[i]) begin
          a = raddr[i*AW +: AW];
          v = ma[a];
          for (int j = 0; j < NW; j++)
            if (we[j] && waddr[j*AW +: AW] == a) v = wdata[j*DW +: DW];
          if (a == 0) v = '0;
          ea[i*DW +: DW] = v;
          eb[i*DW +: DW] = mb[a];
        end
      end
      for (int j = 0; j < NW; j++) begin
        if (we[j]) begin
          w = waddr[j*AW +: AW];
          if (w != 0) ma[w] = wdata[j*DW +: DW];
          mb[w] = wdata[j*DW +: DW];
        end
      end
      if (clr) begin
        run_m = 1'b0;
        init_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) begin
          ma[k] = '0;
          mb[k] = '0;
        end
      end
    end else if (clr) begin
      init_left = DEPTH;
    end else begin
      init_left--;
      if (init_left == 0) run_m = 1'b1;
    end
    e.tag = edge_cnt + 1;
    e.rdy = run_m;
    e.ea  = ea;
    e.eb  = eb;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [NR-1:0] s_re, input logic [NR*AW-1:0] s_ra,
                      input logic [NW-1:0] s_we, input logic [NW*AW-1:0] s_wa,
                      input logic [NW*DW-1:0] s_wd, input logic s_clr);
    @(negedge clk);
    re = s_re; raddr = s_ra; we = s_we; waddr = s_wa; wdata = s_wd; clr = s_clr;
    model_edge();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic rand_step(input int clr_pct);
    logic [NR*AW-1:0] ra;
    logic [NW*AW-1:0] wa;
    logic [NW*DW-1:0] wd;
    for (int i = 0; i < NR; i++) ra[i*AW +: AW] = rand_addr();
    for (int j = 0; j < NW; j++) begin
      wa[j*AW +: AW] = rand_addr();
      wd[j*DW +: DW] = {$urandom(), $urandom()};
    end
    step(NR'($urandom()), ra, NW'($urandom()), wa, wd,
         ($urandom_range(0, 99) < clr_pct));
  endtask

  task automatic read_all();
    logic [NR*AW-1:0] ra;
    for (int k = 0; k < DEPTH / NR; k++) begin
      for (int i = 0; i < NR; i++) ra[i*AW +: AW] = AW'(k * NR + i);
      step('1, ra, '0, '0, '0, 1'b0);
    end
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("reset_ready_a", NR*DW'(ready_a), '0);
    check("reset_ready_b", NR*DW'(ready_b), '0);
    check("reset_rdata_a", rdata_a, '0);
    check("reset_rdata_b", rdata_b, '0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0; clr = 1'b0;
    model_edge();
  endtask

  always @(posedge clk) begin
    exp_t e;
    edge_cnt++;
    #1;
    while (sbq.size() > 0 && sbq[0].tag <= edge_cnt) begin
      e = sbq.pop_front();
      check("ready_a", NR*DW'(ready_a), NR*DW'(e.rdy));
      check("ready_b", NR*DW'(ready_b), NR*DW'(e.rdy));
      check("rdata_a", rdata_a, e.ea);
      check("rdata_b", rdata_b, e.eb);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    clr = 1'b0; re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("por_ready_a", NR*DW'(ready_a), '0);
    check("por_rdata_a", rdata_a, '0);
    check("por_rdata_b", rdata_b, '0);

    // init with random traffic that must be ignored, then every entry reads zero
    release_reset();
    for (int k = 0; k < DEPTH - 1; k++) rand_step(0);
    read_all();

    // write-then-read through port 1
    step('0, '0, 2'b01, {5'd0, 5'd7}, {64'd0, 64'hDEAD}, 1'b0);
    step(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, '0, '0, '0, 1'b0);

    // same-cycle WAW on address 3 with a read of it
    step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, 2'b11, {5'd3, 5'd3}, {64'h22, 64'h11}, 1'b0);
    step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, '0, '0, '0, 1'b0);

    // entry 0
    step('0, '0, 2'b01, {5'd0, 5'd0}, {64'd0, 64'hFF}, 1'b0);
    step('1, '0, '0, '0, '0, 1'b0);

    for (int k = 0; k < 400; k++) rand_step(1);
    for (int k = 0; k < 40; k++) rand_step(0);

    // fill 1..31 (and 0), clear mid-run with writes during init, then read back
    for (int k = 0; k < DEPTH / 2; k++)
      step('0, '0, 2'b11, {AW'(2 * k + 1), AW'(2 * k)},
           {{$urandom(), $urandom()} | 64'h1, {$urandom(), $urandom()} | 64'h1}, 1'b0);
    read_all();
    step('0, '0, '0, '0, '0, 1'b1);
    for (int k = 0; k < DEPTH + 4; k++) rand_step(0);
    read_all();

    // async reset when the init counter sits at 10
    async_reset_check();
    release_reset();
    for (int k = 0; k < 9; k++) rand_step(0);
    async_reset_check();
    release_reset();
    for (int k = 0; k < DEPTH - 1; k++) rand_step(0);
    read_all();
    for (int k = 0; k < 100; k++) rand_step(0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
